tape_in_conditioner: RTL and testbench



---
 rtl/tape_in_conditioner.sv | 160 ++++++++++++++++
 tb/tb_tape_in_conditioner.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tape_in_conditioner.sv
// tape_in_conditioner: cassette input sync, glitch filter, half-period tone classifier and carrier lock.
// Define TAPE_STATS_EN to add ERR_CNT, a saturating count of out-of-window half-periods while locked.
module tape_in_conditioner #(
  parameter int CE_DIV      = 12,
  parameter int FILT_LEN    = 8,
  parameter int PERIOD_W    = 12,
  parameter int CARRIER_MIN = 16,
  parameter int ACT_TICKS   = 100000
) (
  input  logic                CLK12,
  input  logic                RESET_N,
  input  logic                ENABLE,
  input  logic                CASS_RAW,
  output logic                CASS_OUT,
  output logic                EDGE,
  output logic [PERIOD_W-1:0] HALF_PERIOD,
  output logic                HALF_VALID,
  output logic                TONE,
  output logic                CARRIER,
  output logic                ACTIVITY
`ifdef TAPE_STATS_EN
  ,
  output logic [7:0]          ERR_CNT
`endif
);
  localparam int DW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int RW = $clog2(CARRIER_MIN + 1);
  localparam int AW = (ACT_TICKS > 1) ? $clog2(ACT_TICKS) : 1;
  localparam logic [FW-1:0] F_MAX = FW'(FILT_LEN - 1);
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
  logic                s1_q, s2_q;
  logic [DW-1:0]       div_q, div_d;
  logic                tick;
  logic [FW-1:0]       f_q, f_d;
  logic                out_q, out_d, prev_q, edge_q;
  logic [PERIOD_W-1:0] p_q, p_d, half_q, half_d;
  logic                tone_q, tone_d;
  state_t              state_q, state_d;
  logic [RW-1:0]       r_q, r_d;
  logic [2:0]          m_q, m_d;
  logic                carrier_q, carrier_d;
  logic [AW-1:0]       a_q, a_d;
  logic                is_short, is_long, in_win;
  assign tick     = div_q == DW'(CE_DIV - 1);
  assign div_d    = tick ? '0 : div_q + DW'(1);
  assign is_short = (p_q >= PERIOD_W'(150)) && (p_q <= PERIOD_W'(280));
  assign is_long  = (p_q >= PERIOD_W'(330)) && (p_q <= PERIOD_W'(520));
  assign in_win   = is_short || is_long;
  always_comb begin
    f_d   = f_q;
    out_d = out_q;
    if (tick) begin
      f_d   = s2_q ? ((f_q == F_MAX) ? f_q : f_q + FW'(1)) : ((f_q == '0) ? f_q : f_q - FW'(1));
      out_d = (f_d == F_MAX) ? 1'b1 : (f_d == '0) ? 1'b0 : out_q;
    end
  end
  // An edge restarts the period count; a coincident tick is dropped.
  assign p_d    = edge_q ? '0 : (tick && p_q != '1) ? p_q + PERIOD_W'(1) : p_q;
  assign half_d = edge_q ? p_q : half_q;
  assign tone_d = (edge_q && is_short) ? 1'b1 : (edge_q && is_long) ? 1'b0 : tone_q;
  assign a_d    = edge_q ? AW'(ACT_TICKS - 1) : (tick && a_q != '0) ? a_q - AW'(1) : a_q;
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    m_d     = m_q;
    if (!ENABLE) begin
      state_d = IDLE;
      r_d     = '0;
      m_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          r_d     = '0;
          m_d     = '0;
        end
        ACQUIRE: begin
          m_d = '0;
          if (edge_q) begin
            r_d = in_win ? r_q + RW'(1) : '0;
            if (in_win && r_q == RW'(CARRIER_MIN - 1)) state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (edge_q) begin
            m_d = in_win ? '0 : m_q + 3'd1;
            if (!in_win && m_q == 3'd3) begin
              state_d = ACQUIRE;
              r_d     = '0;
            end
          end else if (p_q >= PERIOD_W'(1000)) begin
            state_d = ACQUIRE;
            r_d     = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  assign carrier_d = state_d == LOCKED;
  always_ff @(posedge CLK12 or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      div_q     <= '0;
      f_q       <= '0;
      out_q     <= 1'b0;
      prev_q    <= 1'b0;
      edge_q    <= 1'b0;
      p_q       <= '0;
      half_q    <= '0;
      tone_q    <= 1'b0;
      state_q   <= IDLE;
      r_q       <= '0;
      m_q       <= '0;
      carrier_q <= 1'b0;
      a_q       <= '0;
    end else begin
      s1_q      <= CASS_RAW;
      s2_q      <= s1_q;
      div_q     <= div_d;
      f_q       <= f_d;
      out_q     <= out_d;
      prev_q    <= out_q;
      edge_q    <= out_q != prev_q;
      p_q       <= p_d;
      half_q    <= half_d;
      tone_q    <= tone_d;
      state_q   <= state_d;
      r_q       <= r_d;
      m_q       <= m_d;
      carrier_q <= carrier_d;
      a_q       <= a_d;
    end
  end
`ifdef TAPE_STATS_EN
  logic       en_q;
  logic [7:0] err_q, err_d;
  assign err_d = (ENABLE && !en_q) ? 8'd0 :
                 (ENABLE && state_q == LOCKED && edge_q && !in_win && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  always_ff @(posedge CLK12 or negedge RESET_N) begin
    if (!RESET_N) begin
      en_q  <= 1'b0;
      err_q <= '0;
    end else begin
      en_q  <= ENABLE;
      err_q <= err_d;
    end
  end
  assign ERR_CNT = err_q;
`endif
  assign CASS_OUT    = out_q;
  assign EDGE        = edge_q;
  assign HALF_VALID  = edge_q;
  assign HALF_PERIOD = half_q;
  assign TONE        = tone_q;
  assign CARRIER     = carrier_q;
  assign ACTIVITY    = a_q != '0;
endmodule

// File: tb/tb_tape_in_conditioner.sv
// tb_tape_in_conditioner: directed checks of filtering, tone classification, carrier lock and activity.
`timescale 1ns/1ps
module tb_tape_in_conditioner;
  localparam int CE = 2;
  localparam int PW = 12;
  logic CLK12 = 1'b0, RESET_N = 1'b0, ENABLE = 1'b0, CASS_RAW = 1'b0;
  logic CASS_OUT, EDGE, HALF_VALID, TONE, CARRIER, ACTIVITY;
  logic [PW-1:0] HALF_PERIOD;
`ifdef TAPE_STATS_EN
  logic [7:0] ERR_CNT;
`endif
  int checks = 0, errors = 0, edge_cnt = 0;

  tape_in_conditioner #(.CE_DIV(CE), .FILT_LEN(8), .PERIOD_W(PW), .CARRIER_MIN(16), .ACT_TICKS(1500)) dut (
    .CLK12(CLK12), .RESET_N(RESET_N), .ENABLE(ENABLE), .CASS_RAW(CASS_RAW),
    .CASS_OUT(CASS_OUT), .EDGE(EDGE), .HALF_PERIOD(HALF_PERIOD), .HALF_VALID(HALF_VALID),
    .TONE(TONE), .CARRIER(CARRIER), .ACTIVITY(ACTIVITY)
`ifdef TAPE_STATS_EN
    , .ERR_CNT(ERR_CNT)
`endif
  );

  always #41.667 CLK12 = ~CLK12;
  always @(negedge CLK12) if (EDGE) edge_cnt <= edge_cnt + 1;

  task automatic us(input int n);
    repeat (n * CE) @(negedge CLK12);
  endtask

  task automatic half(input int n);
    CASS_RAW = ~CASS_RAW;
    us(n);
  endtask

  task automatic test_reset;
    RESET_N = 1'b0; ENABLE = 1'b0; CASS_RAW = 1'b0;
    us(5);
    checks++;
    if ({CASS_OUT, EDGE, HALF_VALID, TONE, CARRIER, ACTIVITY} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got %b want 000000", {CASS_OUT, EDGE, HALF_VALID, TONE, CARRIER, ACTIVITY});
    end
    checks++;
    if (HALF_PERIOD !== '0) begin errors++; $display("FAIL reset_half got %0d want 0", HALF_PERIOD); end
`ifdef TAPE_STATS_EN
    checks++;
    if (ERR_CNT !== 8'd0) begin errors++; $display("FAIL reset_err got %0d want 0", ERR_CNT); end
`endif
  endtask

  task automatic test_lock_2400;
    ENABLE = 1'b1;
    RESET_N = 1'b1;
    for (int i = 0; i < 16; i++) half(208);
    checks++;
    if (CARRIER !== 1'b0) begin errors++; $display("FAIL lock_early got %b want 0", CARRIER); end
    checks++;
    if (edge_cnt != 16) begin errors++; $display("FAIL lock_edges got %0d want 16", edge_cnt); end
    half(208);
    checks++;
    if (CARRIER !== 1'b1) begin errors++; $display("FAIL lock_carrier got %b want 1", CARRIER); end
    checks++;
    if (TONE !== 1'b1) begin errors++; $display("FAIL lock_tone got %b want 1", TONE); end
    checks++;
    if (HALF_PERIOD < 207 || HALF_PERIOD > 209) begin errors++; $display("FAIL lock_half got %0d want 207..209", HALF_PERIOD); end
    checks++;
    if (ACTIVITY !== 1'b1) begin errors++; $display("FAIL lock_activity got %b want 1", ACTIVITY); end
  endtask

  task automatic test_tone_1200;
    half(417);
    checks++;
    if (TONE !== 1'b1) begin errors++; $display("FAIL t1200_pre_tone got %b want 1", TONE); end
    half(417);
    checks++;
    if (TONE !== 1'b0) begin errors++; $display("FAIL t1200_tone got %b want 0", TONE); end
    checks++;
    if (HALF_PERIOD < 416 || HALF_PERIOD > 418) begin errors++; $display("FAIL t1200_half got %0d want 416..418", HALF_PERIOD); end
    half(417);
    checks++;
    if (CARRIER !== 1'b1) begin errors++; $display("FAIL t1200_carrier got %b want 1", CARRIER); end
  endtask

  task automatic test_enable_drop;
    bit hit = 1'b0;
    CASS_RAW = ~CASS_RAW;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge CLK12);
      if (EDGE === 1'b1) hit = 1'b1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL endrop_edge_timeout got none want EDGE"); end
    ENABLE = 1'b0;
    @(negedge CLK12);
    ENABLE = 1'b1;
    checks++;
    if (CARRIER !== 1'b0) begin errors++; $display("FAIL endrop_carrier got %b want 0", CARRIER); end
    us(200);
    for (int i = 0; i < 15; i++) half(208);
    checks++;
    if (CARRIER !== 1'b0) begin errors++; $display("FAIL endrop_relock_early got %b want 0", CARRIER); end
    half(208);
    checks++;
    if (CARRIER !== 1'b1) begin errors++; $display("FAIL endrop_relock got %b want 1", CARRIER); end
  endtask

  task automatic test_miss;
    for (int i = 0; i < 4; i++) half(100);
    checks++;
    if (CARRIER !== 1'b1) begin errors++; $display("FAIL miss3_carrier got %b want 1", CARRIER); end
`ifdef TAPE_STATS_EN
    checks++;
    if (ERR_CNT !== 8'd3) begin errors++; $display("FAIL miss3_err got %0d want 3", ERR_CNT); end
`endif
    half(20);
    checks++;
    if (CARRIER !== 1'b0) begin errors++; $display("FAIL miss4_carrier got %b want 0", CARRIER); end
`ifdef TAPE_STATS_EN
    checks++;
    if (ERR_CNT !== 8'd4) begin errors++; $display("FAIL miss4_err got %0d want 4", ERR_CNT); end
`endif
  endtask

`ifdef TAPE_STATS_EN
  task automatic test_stats_saturate;
    for (int i = 0; i < 18; i++) half(208);
    checks++;
    if (CARRIER !== 1'b1) begin errors++; $display("FAIL sat_lock got %b want 1", CARRIER); end
    for (int r = 0; r < 86; r++) begin
      half(155);
      for (int j = 0; j < 3; j++) half(12);
      if (r == 0) begin
        checks++;
        if (ERR_CNT !== 8'd6) begin errors++; $display("FAIL sat_round1 got %0d want 6", ERR_CNT); end
      end
    end
    checks++;
    if (ERR_CNT !== 8'd255) begin errors++; $display("FAIL sat_err got %0d want 255", ERR_CNT); end
    checks++;
    if (CARRIER !== 1'b1) begin errors++; $display("FAIL sat_carrier got %b want 1", CARRIER); end
  endtask
`endif

  task automatic test_window;
    int  w[7] = '{521, 281, 331, 282, 151, 522, 330};
    bit  t[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    half(w[0]);
    for (int i = 0; i < 7; i++) begin
      CASS_RAW = ~CASS_RAW;
      us(15);
      checks++;
      if (HALF_PERIOD != PW'(w[i] - 1) || TONE !== t[i]) begin
        errors++; $display("FAIL window_%0d got half %0d tone %b want half %0d tone %b", i, HALF_PERIOD, TONE, w[i] - 1, t[i]);
      end
      if (i < 6) us(w[i + 1] - 15);
    end
  endtask

  task automatic test_glitch;
    int base;
    CASS_RAW = 1'b0;
    us(30);
    base = edge_cnt;
    for (int i = 0; i < 5; i++) begin
      CASS_RAW = 1'b1; us(3);
      CASS_RAW = 1'b0; us(20);
    end
    checks++;
    if (CASS_OUT !== 1'b0 || edge_cnt != base) begin
      errors++; $display("FAIL glitch_short got out %b edges %0d want out 0 edges %0d", CASS_OUT, edge_cnt, base);
    end
    CASS_RAW = 1'b1; us(10);
    CASS_RAW = 1'b0; us(40);
    checks++;
    if (edge_cnt != base + 2) begin errors++; $display("FAIL glitch_10us got %0d edges want %0d", edge_cnt - base, 2); end
  endtask

  task automatic test_carrier_loss;
    for (int i = 0; i < 18; i++) half(208);
    checks++;
    if (CARRIER !== 1'b1) begin errors++; $display("FAIL loss_lock got %b want 1", CARRIER); end
    us(692);
    checks++;
    if (CARRIER !== 1'b1) begin errors++; $display("FAIL loss_900 got %b want 1", CARRIER); end
    us(200);
    checks++;
    if (CARRIER !== 1'b0 || ACTIVITY !== 1'b1) begin
      errors++; $display("FAIL loss_1100 got carrier %b activity %b want 0 1", CARRIER, ACTIVITY);
    end
    us(300);
    checks++;
    if (ACTIVITY !== 1'b1) begin errors++; $display("FAIL act_1400 got %b want 1", ACTIVITY); end
    us(200);
    checks++;
    if (ACTIVITY !== 1'b0) begin errors++; $display("FAIL act_1600 got %b want 0", ACTIVITY); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) half(208);
    checks++;
    if (ACTIVITY !== 1'b1 || TONE !== 1'b1) begin
      errors++; $display("FAIL mid_pre got activity %b tone %b want 1 1", ACTIVITY, TONE);
    end
    #2 RESET_N = 1'b0;
    CASS_RAW = 1'b0;
    #1;
    checks++;
    if ({CASS_OUT, EDGE, HALF_VALID, TONE, CARRIER, ACTIVITY} !== 6'b0 || HALF_PERIOD !== '0) begin
      errors++; $display("FAIL mid_reset got flags %b half %0d want 000000 0", {CASS_OUT, EDGE, HALF_VALID, TONE, CARRIER, ACTIVITY}, HALF_PERIOD);
    end
    us(2);
    RESET_N = 1'b1;
    us(100);
    CASS_RAW = 1'b1;
    us(30);
    checks++;
    if (HALF_PERIOD < 104 || HALF_PERIOD > 112 || CASS_OUT !== 1'b1) begin
      errors++; $display("FAIL post_reset_first got half %0d out %b want 104..112 1", HALF_PERIOD, CASS_OUT);
    end
  endtask

  initial begin
    test_reset;
    test_lock_2400;
    test_tone_1200;
    test_enable_drop;
    test_miss;
`ifdef TAPE_STATS_EN
    test_stats_saturate;
`endif
    test_window;
    test_glitch;
    test_carrier_loss;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
